// File: rtl/rr_grant_sched.sv
// Round-robin grant scheduler: one owner at a time, held until release, last beat or hold timeout.
// Grant is presented as a binary mux select and as a one-hot acknowledge. A one-cycle GAP separates grants.

module rr_grant_lane #(
    parameter int IDX_WTH = 3,
    parameter int LANE    = 0
) (
    input  logic [IDX_WTH-1:0] i_ptr,
    input  logic               i_req,
    output logic               o_hi
);
    // Marks a request at or above the priority pointer (first half of the rotated scan).
    assign o_hi = i_req && (IDX_WTH'(LANE) >= i_ptr);
endmodule

module rr_grant_sched #(
    parameter int REQ_NUM  = 8,
    parameter int IDX_WTH  = 3,
    parameter int MAX_HOLD = 64,
    parameter int CNT_WTH  = 7
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [REQ_NUM-1:0] req_i,
    input  logic               last_i,
    output logic               gnt_vld_o,
    output logic [IDX_WTH-1:0] gnt_idx_o,
    output logic [REQ_NUM-1:0] gnt_oh_o,
    output logic               timeout_o,
    output logic               busy_o
);
    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

    localparam logic [IDX_WTH-1:0] LAST_IDX = IDX_WTH'(REQ_NUM - 1);
    localparam logic [CNT_WTH-1:0] CNT_TOP  = CNT_WTH'(MAX_HOLD - 1);

    state_t             r_state;
    logic [IDX_WTH-1:0] r_ptr;
    logic [CNT_WTH-1:0] r_cnt;
    logic               r_gnt_vld;
    logic [IDX_WTH-1:0] r_gnt_idx;
    logic [REQ_NUM-1:0] r_gnt_oh;
    logic               r_timeout;
    logic               r_busy;

    logic [REQ_NUM-1:0] w_hi;
    logic [REQ_NUM-1:0] w_pick;
    logic [IDX_WTH-1:0] w_win;
    logic [REQ_NUM-1:0] w_win_oh;
    logic               w_any;
    logic               w_own_req;
    logic               w_hold_top;
    logic               w_release;
    logic               w_timeout;
    logic [IDX_WTH-1:0] w_ptr_nxt;

    genvar g;
    generate
        for (g = 0; g < REQ_NUM; g++) begin : g_lane
            rr_grant_lane #(.IDX_WTH(IDX_WTH), .LANE(g)) u_lane (
                .i_ptr (r_ptr),
                .i_req (req_i[g]),
                .o_hi  (w_hi[g])
            );
        end
    endgenerate

    // Rotated scan: lowest request at/above ptr wins, else wrap to lowest request overall.
    always_comb begin
        w_any  = |req_i;
        w_pick = (|w_hi) ? w_hi : req_i;
        w_win  = '0;
        for (int k = REQ_NUM - 1; k >= 0; k--) begin
            if (w_pick[k]) w_win = IDX_WTH'(k);
        end
        w_win_oh = REQ_NUM'(1) << w_win;
    end

    assign w_own_req  = req_i[r_gnt_idx];
    assign w_hold_top = (r_cnt == CNT_TOP);
    assign w_release  = !w_own_req || last_i || w_hold_top;
    assign w_timeout  = w_hold_top && w_own_req && !last_i;
    assign w_ptr_nxt  = (r_gnt_idx == LAST_IDX) ? '0 : r_gnt_idx + 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_gnt_vld <= 1'b0;
            r_gnt_idx <= '0;
            r_gnt_oh  <= '0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_GRANT: begin
                    if (w_release) begin
                        r_state   <= S_GAP;
                        r_gnt_vld <= 1'b0;
                        r_gnt_oh  <= '0;
                        r_ptr     <= w_ptr_nxt;
                        r_timeout <= w_timeout;
                        r_busy    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    // IDLE and GAP arbitrate identically; GAP simply sees the advanced ptr.
                    if (w_any) begin
                        r_state   <= S_GRANT;
                        r_gnt_vld <= 1'b1;
                        r_gnt_idx <= w_win;
                        r_gnt_oh  <= w_win_oh;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign gnt_vld_o = r_gnt_vld;
    assign gnt_idx_o = r_gnt_idx;
    assign gnt_oh_o  = r_gnt_oh;
    assign timeout_o = r_timeout;
    assign busy_o    = r_busy;

endmodule

// File: tb/tb_rr_grant_sched.sv
// Bench for rr_grant_sched: directed scenarios plus random traffic, all checked against a
// cycle-level reference model built from the arbitration and release rules.

module tb_rr_grant_sched;
    localparam int N    = 8;
    localparam int HOLD = 64;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic         last;
    logic         gnt_vld;
    logic [2:0]   gnt_idx;
    logic [N-1:0] gnt_oh;
    logic         timeout;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int m_owner = -1;
    int m_gap   = 0;
    int m_ptr   = 0;
    int m_hold  = 0;
    int m_idx   = 0;
    int m_to    = 0;

    rr_grant_sched #(.REQ_NUM(N), .IDX_WTH(3), .MAX_HOLD(HOLD), .CNT_WTH(7)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .last_i    (last),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx),
        .gnt_oh_o  (gnt_oh),
        .timeout_o (timeout),
        .busy_o    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic l, input logic rs);
        int w;
        if (!rs) begin
            m_owner = -1; m_gap = 0; m_ptr = 0; m_hold = 0; m_idx = 0; m_to = 0;
        end else if (m_owner >= 0) begin
            m_to = 0;
            if (!r[m_owner] || l || m_hold == HOLD - 1) begin
                m_to    = (r[m_owner] && !l && m_hold == HOLD - 1) ? 1 : 0;
                m_ptr   = (m_owner + 1) % N;
                m_idx   = m_owner;
                m_owner = -1;
                m_gap   = 1;
            end else begin
                m_hold++;
            end
        end else begin
            m_to  = 0;
            m_gap = 0;
            w = -1;
            for (int i = 0; i < N; i++) begin
                if (w < 0 && r[(m_ptr + i) % N]) w = (m_ptr + i) % N;
            end
            if (w >= 0) begin
                m_owner = w; m_idx = w; m_hold = 0;
            end
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare just after it.
    task automatic cyc(input logic [N-1:0] r, input logic l, input logic rs);
        int exp_vld;
        req = r; last = l; rst = rs;
        @(posedge clk);
        model_step(r, l, rs);
        #1;
        exp_vld = (m_owner >= 0) ? 1 : 0;
        chk("gnt_vld", 32'(gnt_vld), 32'(exp_vld));
        chk("gnt_idx", 32'(gnt_idx), 32'(m_idx));
        chk("gnt_oh", 32'(gnt_oh), exp_vld ? (32'd1 << m_idx) : 32'd0);
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("busy", 32'(busy), 32'((m_owner >= 0 || m_gap) ? 1 : 0));
    endtask

    initial begin
        int order[$];
        int vcnt;
        int tcnt;
        int prev_vld;
        logic [N-1:0] r;
        req = '0; last = 1'b0; rst = 1'b0;

        // reset and quiet idle
        cyc('0, 0, 0);
        cyc('0, 0, 0);
        chk("rst_vld", 32'(gnt_vld), 0);
        chk("rst_busy", 32'(busy), 0);
        for (int i = 0; i < 10; i++) cyc('0, 0, 1);
        chk("idle_oh", 32'(gnt_oh), 0);

        // 0x24 from ptr=0 -> 2, then release -> GAP -> 5
        cyc(8'h24, 0, 1);
        chk("first_idx", 32'(gnt_idx), 2);
        chk("first_oh", 32'(gnt_oh), 32'h04);
        for (int i = 0; i < 4; i++) cyc(8'h24, 0, 1);
        cyc(8'h20, 0, 1);
        chk("gap_vld", 32'(gnt_vld), 0);
        chk("gap_busy", 32'(busy), 1);
        cyc(8'h20, 0, 1);
        chk("next_idx", 32'(gnt_idx), 5);
        chk("next_oh", 32'(gnt_oh), 32'h20);

        // full round robin, last on third grant cycle
        cyc('0, 0, 0);
        prev_vld = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(8'hFF, (m_owner >= 0 && m_hold == 2), 1);
            if (gnt_vld && !prev_vld) order.push_back(int'(gnt_idx));
            prev_vld = int'(gnt_vld);
        end
        chk("rr_count", 32'(order.size()), 10);
        for (int i = 0; i < 9; i++) chk("rr_order", 32'(order[i]), 32'(i % N));

        // hold timeout on requester 1
        cyc('0, 0, 0);
        vcnt = 0; tcnt = 0;
        cyc(8'h02, 0, 1);
        for (int i = 0; i < 100 && gnt_vld; i++) begin
            vcnt++;
            cyc(8'h02, 0, 1);
        end
        tcnt += int'(timeout);
        chk("to_len", 32'(vcnt), 64);
        chk("to_pulse", 32'(tcnt), 1);
        cyc(8'h02, 0, 1);
        chk("to_regrant", 32'(gnt_vld), 1);
        chk("to_pulse_end", 32'(timeout), 0);
        chk("to_regrant_idx", 32'(gnt_idx), 1);

        // last coinciding with counter top is a normal release
        cyc('0, 0, 0);
        cyc(8'h02, 0, 1);
        for (int i = 0; i < 63; i++) cyc(8'h02, 0, 1);
        cyc(8'h02, 1, 1);
        chk("last_top_vld", 32'(gnt_vld), 0);
        chk("last_top_to", 32'(timeout), 0);

        // reset mid-grant
        cyc('0, 0, 0);
        cyc(8'h40, 0, 1);
        cyc(8'h40, 0, 1);
        chk("pre_rst_idx", 32'(gnt_idx), 6);
        cyc(8'h40, 0, 0);
        chk("mid_rst_vld", 32'(gnt_vld), 0);
        chk("mid_rst_idx", 32'(gnt_idx), 0);
        chk("mid_rst_to", 32'(timeout), 0);
        cyc(8'h41, 0, 1);
        chk("post_rst_idx", 32'(gnt_idx), 0);

        // random traffic: alternate busy churn and long-hold phases
        r = '0;
        for (int ph = 0; ph < 8; ph++) begin
            for (int i = 0; i < 300; i++) begin
                if (ph % 2 == 0) begin
                    if ($urandom_range(0, 3) == 0) r[$urandom_range(0, N - 1)] ^= 1'b1;
                    cyc(r, ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) != 0));
                end else begin
                    if ($urandom_range(0, 63) == 0) r[$urandom_range(0, N - 1)] ^= 1'b1;
                    cyc(r, ($urandom_range(0, 99) == 0), 1'b1);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
